// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: framebuffer input and VGA output bundle for the scanout block
//   framebuffer           cell bitmap, bit index = row*COLS + col, bit 0 = top-left
//   red/green/blue_out    RGB444 colour channels
//   h_sync_out/v_sync_out active-low sync pulses
//   frame_tick            one-cycle pulse when the framebuffer snapshot is taken
interface framebuffer_scanout_if #(parameter int FB_W = 1200);
  logic [FB_W-1:0] framebuffer;
  logic [3:0]      red_out;
  logic [3:0]      green_out;
  logic [3:0]      blue_out;
  logic            h_sync_out;
  logic            v_sync_out;
  logic            frame_tick;
  modport master (
    input  framebuffer,
    output red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_tick
  );
  modport slave (
    output framebuffer,
    input  red_out, green_out, blue_out, h_sync_out, v_sync_out, frame_tick
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: scans a cell bitmap out as VGA with per-frame snapshot and tick
//   CLOCK_50      system clock, pixel rate is half of it
//   reset_button  asynchronous active-low reset
//   bus (master)  framebuffer in; colour, syncs and frame_tick out
module framebuffer_scanout #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter int          CELL_SHIFT = 4,
  parameter int          H_VIS      = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VIS      = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input logic                    CLOCK_50,
  input logic                    reset_button,
  framebuffer_scanout_if.master  bus
);
  localparam int FB_W  = COLS * ROWS;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int IW    = $clog2(FB_W);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);

  logic            pix_en_q;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [FB_W-1:0] snap_q, snap_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            tick;
  logic            visible;
  logic [HW-1:0]   col;
  logic [VW-1:0]   row;
  logic [IW-1:0]   idx;

  always_comb begin
    tick    = pix_en_q && h_q == '0 && v_q == V_VIS_C;
    h_d     = pix_en_q ? (h_q == H_LAST ? '0 : h_q + HW'(1)) : h_q;
    v_d     = (pix_en_q && h_q == H_LAST) ? (v_q == V_LAST ? '0 : v_q + VW'(1)) : v_q;
    snap_d  = tick ? bus.framebuffer : snap_q;
    visible = h_q < H_VIS_C && v_q < V_VIS_C;
    col     = h_q >> CELL_SHIFT;
    row     = v_q >> CELL_SHIFT;
    // index is only meaningful while visible; parked at 0 otherwise so it never leaves the bitmap
    idx     = visible ? IW'(row) * IW'(COLS) + IW'(col) : '0;
    rgb_d   = pix_en_q ? (visible ? (snap_q[idx] ? FG_COLOR : BG_COLOR) : 12'h000) : rgb_q;
    hs_d    = pix_en_q ? !(h_q >= HS_BEG && h_q < HS_END) : hs_q;
    vs_d    = pix_en_q ? !(v_q >= VS_BEG && v_q < VS_END) : vs_q;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      snap_q   <= '0;
      rgb_q    <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      pix_en_q <= !pix_en_q;
      h_q      <= h_d;
      v_q      <= v_d;
      snap_q   <= snap_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign bus.red_out    = rgb_q[11:8];
  assign bus.green_out  = rgb_q[7:4];
  assign bus.blue_out   = rgb_q[3:0];
  assign bus.h_sync_out = hs_q;
  assign bus.v_sync_out = vs_q;
  assign bus.frame_tick = tick;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: scoreboard bench for framebuffer_scanout on a reduced raster
module tb_framebuffer_scanout;
  localparam int COLS = 4, ROWS = 3, CS = 1;
  localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int FB_W  = COLS * ROWS;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLK = 2 * H_TOT * V_TOT;
  localparam int ALIGN = 2 * (V_TOT - V_VIS) * H_TOT;
  localparam int LIMIT = FRAME_CLK + 50;

  logic clk = 0;
  logic reset_button = 0;
  int   checks = 0;
  int   failures = 0;
  logic [11:0] exp_q[$];

  framebuffer_scanout_if #(.FB_W(FB_W)) bus ();

  framebuffer_scanout #(
    .COLS(COLS), .ROWS(ROWS), .CELL_SHIFT(CS),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .CLOCK_50(clk),
    .reset_button(reset_button),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rgb();
    return {bus.red_out, bus.green_out, bus.blue_out};
  endfunction

  task automatic push_frame(input logic [FB_W-1:0] img);
    for (int y = 0; y < V_VIS; y++)
      for (int x = 0; x < H_VIS; x++)
        exp_q.push_back(img[(y >> CS) * COLS + (x >> CS)] ? 12'hFFF : 12'h000);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (bus.frame_tick !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      failures++;
      $display("FAIL %s: frame_tick not seen within %0d cycles", tag, LIMIT);
    end
  endtask

  task automatic scan_frame(input string tag, input int chg_line, input logic [FB_W-1:0] new_fb);
    logic [11:0] e;
    logic hs_e;
    for (int y = 0; y < V_VIS; y++)
      for (int x = 0; x < H_TOT; x++) begin
        if (y == chg_line && x == 0) bus.framebuffer = new_fb;
        e = 12'h000;
        if (x < H_VIS) begin
          if (exp_q.size() == 0) e = 12'hBAD;
          else e = exp_q.pop_front();
        end
        hs_e = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
        checks++;
        if (rgb() !== e || bus.h_sync_out !== hs_e || bus.v_sync_out !== 1'b1) begin
          failures++;
          $display("FAIL %s pix(%0d,%0d): rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=1",
                   tag, x, y, rgb(), bus.h_sync_out, bus.v_sync_out, e, hs_e);
        end
        repeat (2) @(negedge clk);
      end
  endtask

  task automatic test_reset();
    int n = 0;
    bus.framebuffer = '0;
    reset_button = 0;
    repeat (10) @(negedge clk);
    checks += 4;
    if (rgb() !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h expected 000", rgb()); end
    if (bus.h_sync_out !== 1'b1) begin failures++; $display("FAIL reset_hs: got %b expected 1", bus.h_sync_out); end
    if (bus.v_sync_out !== 1'b1) begin failures++; $display("FAIL reset_vs: got %b expected 1", bus.v_sync_out); end
    if (bus.frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); end
    reset_button = 1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.h_sync_out !== 1'b0 && n < 1000);
    checks++;
    if (n != 2 * (H_VIS + H_FP + 1)) begin
      failures++;
      $display("FAIL first_hsync_fall: got %0d cycles expected %0d", n, 2 * (H_VIS + H_FP + 1));
    end
  endtask

  task automatic test_h_timing();
    int lo = 0, hi = 0, n = 0;
    while (bus.h_sync_out !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    while (bus.h_sync_out !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (bus.h_sync_out === 1'b0 && lo < 1000) begin @(negedge clk); lo++; end
    while (bus.h_sync_out === 1'b1 && hi < 1000) begin @(negedge clk); hi++; end
    checks += 2;
    if (lo != 2 * H_SYNC) begin failures++; $display("FAIL hsync_low: got %0d expected %0d", lo, 2 * H_SYNC); end
    if (lo + hi != 2 * H_TOT) begin failures++; $display("FAIL hsync_period: got %0d expected %0d", lo + hi, 2 * H_TOT); end
  endtask

  task automatic test_v_timing();
    int lo = 0, hi = 0, n = 0, w = 0;
    while (bus.v_sync_out !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    while (bus.v_sync_out !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    while (bus.v_sync_out === 1'b0 && lo < LIMIT) begin @(negedge clk); lo++; end
    while (bus.v_sync_out === 1'b1 && hi < LIMIT) begin @(negedge clk); hi++; end
    checks += 2;
    if (lo != 2 * V_SYNC * H_TOT) begin failures++; $display("FAIL vsync_low: got %0d expected %0d", lo, 2 * V_SYNC * H_TOT); end
    if (lo + hi != FRAME_CLK) begin failures++; $display("FAIL vsync_period: got %0d expected %0d", lo + hi, FRAME_CLK); end
    wait_tick("tick_v");
    while (bus.frame_tick === 1'b1 && w < 100) begin @(negedge clk); w++; end
    n = w;
    while (bus.v_sync_out === 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    checks += 2;
    if (w != 1) begin failures++; $display("FAIL tick_width: got %0d expected 1", w); end
    if (n != 2 * (V_FP * H_TOT) + 1) begin failures++; $display("FAIL tick_to_vsync: got %0d expected %0d", n, 2 * V_FP * H_TOT + 1); end
    while (bus.frame_tick !== 1'b1 && n < 2 * LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n != FRAME_CLK) begin failures++; $display("FAIL tick_period: got %0d expected %0d", n, FRAME_CLK); end
  endtask

  task automatic test_pixel_mapping();
    logic [FB_W-1:0] img = '0;
    img[0] = 1'b1;
    img[FB_W-1] = 1'b1;
    bus.framebuffer = img;
    wait_tick("tick_map");
    repeat (ALIGN + 1) @(negedge clk);
    push_frame(img);
    scan_frame("map", -1, img);
  endtask

  task automatic test_snapshot_isolation();
    logic [FB_W-1:0] a = '0, b;
    a[0] = 1'b1;
    a[FB_W-1] = 1'b1;
    b = a;
    b[COLS + 1] = 1'b1;
    bus.framebuffer = a;
    wait_tick("tick_iso");
    repeat (ALIGN + 1) @(negedge clk);
    push_frame(a);
    scan_frame("iso_old", V_VIS / 2, b);
    repeat (ALIGN) @(negedge clk);
    push_frame(b);
    scan_frame("iso_new", -1, b);
  endtask

  task automatic test_reset_midframe();
    logic [FB_W-1:0] ones = '1;
    bus.framebuffer = ones;
    wait_tick("tick_rst");
    repeat (ALIGN + 1 + 2 * (3 * H_TOT + 1)) @(negedge clk);
    checks++;
    if (rgb() !== 12'hFFF) begin failures++; $display("FAIL pre_reset_rgb: got %h expected fff", rgb()); end
    reset_button = 0;
    #1;
    checks += 4;
    if (rgb() !== 12'h000) begin failures++; $display("FAIL mid_reset_rgb: got %h expected 000", rgb()); end
    if (bus.h_sync_out !== 1'b1) begin failures++; $display("FAIL mid_reset_hs: got %b expected 1", bus.h_sync_out); end
    if (bus.v_sync_out !== 1'b1) begin failures++; $display("FAIL mid_reset_vs: got %b expected 1", bus.v_sync_out); end
    if (bus.frame_tick !== 1'b0) begin failures++; $display("FAIL mid_reset_tick: got %b expected 0", bus.frame_tick); end
    repeat (3) @(negedge clk);
    reset_button = 1;
    repeat (2) @(negedge clk);
    push_frame('0);
    scan_frame("post_reset_bg", -1, ones);
    repeat (ALIGN) @(negedge clk);
    push_frame(ones);
    scan_frame("post_reset_img", -1, ones);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.framebuffer = '0;
    @(negedge clk);
    test_reset();
    test_h_timing();
    test_v_timing();
    test_pixel_mapping();
    test_snapshot_isolation();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
